// File: rtl/nano_pkg.sv
// Shared definitions for the nano data-memory arbiter.
//   state_e           : arbiter FSM state encoding
//   WaitStatesDefault : default number of extra memory cycles per access
//   MemAddrW          : width of the data-memory address bus
package nano_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StAck    = 2'd2
  } state_e;

  localparam int unsigned WaitStatesDefault = 1;
  localparam int unsigned MemAddrW          = 16;

endpackage

// File: rtl/nano_rr_arb2.sv
// Two-way round-robin pick.
//   req0_i, req1_i : requests from requester 0 and requester 1
//   last_grant_i   : requester granted last time (0 = req0, 1 = req1)
//   grant_o        : chosen requester (0 = req0, 1 = req1); only meaningful when a req is high
module nano_rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o
);

  // Requester 1 wins when it is the only one asking, or when both ask and
  // requester 0 had the previous grant.
  always_comb begin
    grant_o = req1_i & (~req0_i | ~last_grant_i);
  end

endmodule

// File: rtl/nano_dmem_arbiter.sv
// Arbitrates two requesters (m0 = CPU data port, m1 = loader/debug) onto one
// single-ported data memory with a fixed number of wait states per access.
//   clk, nreset          : clock and asynchronous active-low reset
//   m0_* / m1_*          : requester ports (req/wr/addr/wdata in, rdata/ack out)
//   mem_addr, mem_wdata  : address and write data to the memory, valid during ACCESS
//   mem_wr               : write strobe, first ACCESS cycle of an in-range write only
//   mem_rdata            : read data from the memory, sampled on the last ACCESS edge
// Addresses with any of bits [31:16] set are out of range: writes are dropped,
// reads return zero, and the access is still acknowledged with normal latency.
module nano_dmem_arbiter
  import nano_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WaitStatesDefault
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                m0_req,
  input  logic                m0_wr,
  input  logic [31:0]         m0_addr,
  input  logic [31:0]         m0_wdata,
  output logic [31:0]         m0_rdata,
  output logic                m0_ack,
  input  logic                m1_req,
  input  logic                m1_wr,
  input  logic [31:0]         m1_addr,
  input  logic [31:0]         m1_wdata,
  output logic [31:0]         m1_rdata,
  output logic                m1_ack,
  output logic [MemAddrW-1:0] mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic                mem_wr
);

  localparam logic [2:0] WaitLast = 3'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [2:0]          wait_cnt_q, wait_cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic                wr_q, wr_d;
  logic                oor_q, oor_d;
  logic [MemAddrW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                mem_wr_q, mem_wr_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic [31:0]         m0_rdata_q, m0_rdata_d;
  logic [31:0]         m1_rdata_q, m1_rdata_d;

  logic        arb_grant;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_oor;
  logic [31:0] rd_data;

  nano_rr_arb2 u_rr_arb2 (
    .req0_i       (m0_req),
    .req1_i       (m1_req),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant)
  );

  always_comb begin
    sel_wr    = arb_grant ? m1_wr    : m0_wr;
    sel_addr  = arb_grant ? m1_addr  : m0_addr;
    sel_wdata = arb_grant ? m1_wdata : m0_wdata;
    sel_oor   = |sel_addr[31:16];
    rd_data   = oor_q ? 32'h0 : mem_rdata;
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    oor_d        = oor_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wr_d     = 1'b0;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          state_d      = StAccess;
          wait_cnt_d   = 3'd0;
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          wr_d         = sel_wr;
          oor_d        = sel_oor;
          mem_addr_d   = sel_addr[MemAddrW-1:0];
          mem_wdata_d  = sel_wdata;
          mem_wr_d     = sel_wr & ~sel_oor;
        end
      end
      StAccess: begin
        if (wait_cnt_q == WaitLast) begin
          state_d     = StAck;
          wait_cnt_d  = 3'd0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          m0_ack_d    = ~grant_q;
          m1_ack_d    = grant_q;
          if (!wr_q) begin
            if (grant_q) begin
              m1_rdata_d = rd_data;
            end else begin
              m0_rdata_d = rd_data;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // last_grant resets to 1 so that m0 wins the first contested grant.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= StIdle;
      wait_cnt_q   <= 3'd0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      wr_q         <= 1'b0;
      oor_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_q     <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      oor_q        <= oor_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_q     <= mem_wr_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
